// File: rtl/conv_layer_param.sv
// rtl/conv_layer_param.sv - parametrised multi-channel strided fp32 convolution layer
//
// conv_fp_mul / conv_fp_add : combinational IEEE-754 single-precision units
//   (round to nearest even, denormals flushed to zero, overflow saturates to inf).
// conv_layer_param          : N_UNITS parallel MAC lanes, one output pixel each per batch.
//   clk, reset (sync, active-high), start   -> run control
//   image  [CHANNELS*IMG_H*IMG_W*32]        -> element (c,r,x) at ((c*IMG_H+r)*IMG_W+x)*32
//   filter [CHANNELS*K*K*32]                -> element (c,i,j) at ((c*K+i)*K+j)*32
//   busy, done                              <- run in progress / one-cycle completion pulse
//   outputConv [NPIX*32]                    <- pixel (r,x) at (r*OUT_W+x)*32, registered
// Optional build macro CONV_RELU_EN: negative results (sign bit set) are written as +0.0.

module conv_fp_mul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic              sgn, g, s;
    logic [47:0]       prod;
    logic [22:0]       frac;
    logic [24:0]       rnd;
    logic signed [9:0] e;

    always_comb begin
        sgn  = a[31] ^ b[31];
        prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (prod[47]) begin
            frac = prod[46:24];
            g    = prod[23];
            s    = |prod[22:0];
            e    = e + 10'sd1;
        end else begin
            frac = prod[45:23];
            g    = prod[22];
            s    = |prod[21:0];
        end
        rnd = {2'b01, frac} + {24'd0, g & (s | frac[0])};
        // A carry out of the rounding leaves the fraction at zero, only the exponent moves.
        if (rnd[24]) e = e + 10'sd1;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 10'sd0) y = {sgn, 31'd0};
        else if (e >= 10'sd255)                                    y = {sgn, 8'hFF, 23'd0};
        else                                                       y = {sgn, e[7:0], rnd[22:0]};
    end
endmodule

module conv_fp_add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic              sub, lost;
    logic [31:0]       hi, lo;
    logic [7:0]        dexp;
    logic [26:0]       mhi, mlo, mlo_sh, norm;
    logic [27:0]       sum;
    logic [24:0]       rnd;
    logic signed [9:0] e;

    always_comb begin
        // hi is the operand of larger magnitude, so the aligned difference never goes negative.
        hi     = (b[30:0] > a[30:0]) ? b : a;
        lo     = (b[30:0] > a[30:0]) ? a : b;
        sub    = hi[31] ^ lo[31];
        dexp   = hi[30:23] - lo[30:23];
        mhi    = {1'b1, hi[22:0], 3'b000};
        mlo    = {1'b1, lo[22:0], 3'b000};
        lost   = 1'b0;
        mlo_sh = 27'd1;
        if (dexp <= 8'd26) begin
            mlo_sh = mlo >> dexp;
            lost   = |(mlo & ~({27{1'b1}} << dexp));
            mlo_sh[0] = mlo_sh[0] | lost;
        end
        sum  = sub ? ({1'b0, mhi} - {1'b0, mlo_sh}) : ({1'b0, mhi} + {1'b0, mlo_sh});
        e    = $signed({2'b00, hi[30:23]});
        norm = sum[26:0];
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            e    = e + 10'sd1;
        end else begin
            for (int k = 0; k < 26; k++) begin
                if (!norm[26]) begin
                    norm = {norm[25:0], 1'b0};
                    e    = e - 10'sd1;
                end
            end
        end
        rnd = {1'b0, norm[26:3]} + {24'd0, norm[2] & (norm[1] | norm[0] | norm[3])};
        if (rnd[24]) e = e + 10'sd1;
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) y = 32'd0;
        else if (b[30:23] == 8'd0)                y = a;
        else if (a[30:23] == 8'd0)                y = b;
        else if (sum == 28'd0)                    y = 32'd0;
        else if (e <= 10'sd0)                     y = {hi[31], 31'd0};
        else if (e >= 10'sd255)                   y = {hi[31], 8'hFF, 23'd0};
        else                                      y = {hi[31], e[7:0], rnd[22:0]};
    end
endmodule

module conv_layer_param #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int K          = 5,
    parameter int STRIDE     = 1,
    parameter int CHANNELS   = 1,
    parameter int N_UNITS    = 14
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  start,
    input  logic [CHANNELS*IMG_H*IMG_W*DATA_WIDTH-1:0]            image,
    input  logic [CHANNELS*K*K*DATA_WIDTH-1:0]                    filter,
    output logic                                                  busy,
    output logic                                                  done,
    output logic [((IMG_H-K)/STRIDE+1)*((IMG_W-K)/STRIDE+1)*DATA_WIDTH-1:0] outputConv
);
    localparam int OUT_W  = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H  = (IMG_H - K) / STRIDE + 1;
    localparam int NPIX   = OUT_W * OUT_H;
    localparam int NB     = (NPIX + N_UNITS - 1) / N_UNITS;
    localparam int IMG_AW = $clog2(CHANNELS * IMG_H * IMG_W * DATA_WIDTH);
    localparam int FLT_AW = $clog2(CHANNELS * K * K * DATA_WIDTH);
    localparam int OUT_AW = $clog2(NPIX * DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;
    state_t state, state_nxt;

    int                    batch, tap_c, tap_i, tap_j;
    logic                  last_tap, last_batch;
    logic [DATA_WIDTH-1:0] coef;
    logic [DATA_WIDTH-1:0] acc       [N_UNITS];
    logic [DATA_WIDTH-1:0] acc_nxt   [N_UNITS];
    logic [DATA_WIDTH-1:0] unit_pix  [N_UNITS];
    logic [DATA_WIDTH-1:0] unit_prod [N_UNITS];
    logic [DATA_WIDTH-1:0] unit_wval [N_UNITS];
    logic                  unit_valid[N_UNITS];
    logic [OUT_AW-1:0]     unit_oidx [N_UNITS];

    assign last_tap   = (tap_c == CHANNELS - 1) && (tap_i == K - 1) && (tap_j == K - 1);
    assign last_batch = (batch == NB - 1);
    assign coef       = filter[FLT_AW'(((tap_c * K + tap_i) * K + tap_j) * DATA_WIDTH) +: DATA_WIDTH];

    // Per-lane pixel position and image tap. Lanes beyond the last pixel of a partial
    // batch are pointed at pixel 0 so every slice stays in range; they never write.
    always_comb begin : addr_gen
        int p, q, row, col;
        p = 0; q = 0; row = 0; col = 0;
        for (int u = 0; u < N_UNITS; u++) begin
            p             = batch * N_UNITS + u;
            unit_valid[u] = (p < NPIX);
            q             = unit_valid[u] ? p : 0;
            row           = q / OUT_W;
            col           = q % OUT_W;
            unit_oidx[u]  = OUT_AW'(q * DATA_WIDTH);
            unit_pix[u]   = image[IMG_AW'(((tap_c * IMG_H + row * STRIDE + tap_i) * IMG_W
                                           + col * STRIDE + tap_j) * DATA_WIDTH) +: DATA_WIDTH];
`ifdef CONV_RELU_EN
            unit_wval[u]  = acc[u][DATA_WIDTH-1] ? '0 : acc[u];
`else
            unit_wval[u]  = acc[u];
`endif
        end
    end

    for (genvar u = 0; u < N_UNITS; u++) begin : g_unit
        conv_fp_mul u_mul (.a(unit_pix[u]), .b(coef),         .y(unit_prod[u]));
        conv_fp_add u_add (.a(acc[u]),      .b(unit_prod[u]), .y(acc_nxt[u]));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_MAC;
            S_MAC:   if (last_tap) state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_batch ? S_DONE : S_MAC;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_MAC) || (state == S_WRITE);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            batch      <= 0;
            tap_c      <= 0;
            tap_i      <= 0;
            tap_j      <= 0;
            outputConv <= '0;
            for (int u = 0; u < N_UNITS; u++) acc[u] <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    batch <= 0;
                    tap_c <= 0;
                    tap_i <= 0;
                    tap_j <= 0;
                    for (int u = 0; u < N_UNITS; u++) acc[u] <= '0;
                end
                S_MAC: begin
                    for (int u = 0; u < N_UNITS; u++) acc[u] <= acc_nxt[u];
                    // Tap order c, i, j with j fastest; counters wrap to 0 on the last tap.
                    if (tap_j == K - 1) begin
                        tap_j <= 0;
                        if (tap_i == K - 1) begin
                            tap_i <= 0;
                            tap_c <= (tap_c == CHANNELS - 1) ? 0 : tap_c + 1;
                        end else begin
                            tap_i <= tap_i + 1;
                        end
                    end else begin
                        tap_j <= tap_j + 1;
                    end
                end
                S_WRITE: begin
                    for (int u = 0; u < N_UNITS; u++) begin
                        acc[u] <= '0;
                        if (unit_valid[u]) outputConv[unit_oidx[u] +: DATA_WIDTH] <= unit_wval[u];
                    end
                    if (!last_batch) batch <= batch + 1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_layer_param.sv
// tb/tb_conv_layer_param.sv - self-checking bench for conv_layer_param (three configurations)
module tb_conv_layer_param;
    localparam int W0 = 32, H0 = 32, K0 = 5, S0 = 1, C0 = 1, N0 = 14, OW0 = 28, NP0 = 784;
    localparam int W1 = 8,  H1 = 8,  K1 = 3, S1 = 2, C1 = 1, N1 = 4,  OW1 = 3,  NP1 = 9;
    localparam int W2 = 8,  H2 = 8,  K2 = 3, S2 = 1, C2 = 2, N2 = 14, OW2 = 6,  NP2 = 36;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst0, rst1, rst2, st0, st1, st2, busy0, busy1, busy2, done0, done1, done2;
    logic [C0*H0*W0*32-1:0] img0;
    logic [C1*H1*W1*32-1:0] img1;
    logic [C2*H2*W2*32-1:0] img2;
    logic [C0*K0*K0*32-1:0] flt0;
    logic [C1*K1*K1*32-1:0] flt1;
    logic [C2*K2*K2*32-1:0] flt2;
    logic [NP0*32-1:0]      out0;
    logic [NP1*32-1:0]      out1;
    logic [NP2*32-1:0]      out2;

    conv_layer_param #(.DATA_WIDTH(32), .IMG_W(W0), .IMG_H(H0), .K(K0), .STRIDE(S0), .CHANNELS(C0), .N_UNITS(N0))
        dut0 (.clk(clk), .reset(rst0), .start(st0), .image(img0), .filter(flt0), .busy(busy0), .done(done0), .outputConv(out0));
    conv_layer_param #(.DATA_WIDTH(32), .IMG_W(W1), .IMG_H(H1), .K(K1), .STRIDE(S1), .CHANNELS(C1), .N_UNITS(N1))
        dut1 (.clk(clk), .reset(rst1), .start(st1), .image(img1), .filter(flt1), .busy(busy1), .done(done1), .outputConv(out1));
    conv_layer_param #(.DATA_WIDTH(32), .IMG_W(W2), .IMG_H(H2), .K(K2), .STRIDE(S2), .CHANNELS(C2), .N_UNITS(N2))
        dut2 (.clk(clk), .reset(rst2), .start(st2), .image(img2), .filter(flt2), .busy(busy2), .done(done2), .outputConv(out2));

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        int          d;
        logic [31:0] i0, i1, f, px;
        int          lat;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic get_done(input int d);
        case (d) 0: return done0; 1: return done1; default: return done2; endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d) 0: return busy0; 1: return busy1; default: return busy2; endcase
    endfunction

    function automatic logic [31:0] get_pix(input int d, input int p);
        case (d) 0: return out0[p*32 +: 32]; 1: return out1[p*32 +: 32]; default: return out2[p*32 +: 32]; endcase
    endfunction

    task automatic set_start(input int d, input logic v);
        case (d) 0: st0 = v; 1: st1 = v; default: st2 = v; endcase
    endtask

    function automatic logic [31:0] i2f(input int v);
        int          m;
        logic [31:0] vv;
        if (v == 0) return 32'd0;
        m = 0;
        for (int b = 0; b < 31; b++) if (((v >> b) & 1) != 0) m = b;
        vv = v;
        vv = vv << (23 - m);
        return {1'b0, 8'(127 + m), vv[22:0]};
    endfunction

    function automatic int img_v(input int c, input int r, input int x);
        return c * 64 + r * 8 + x;
    endfunction

    function automatic int flt_v(input int c, input int i, input int j);
        return c * 9 + i * 3 + j + 1;
    endfunction

    function automatic int ref_px(input int k, input int s, input int ch, input int r, input int x);
        int a = 0;
        for (int c = 0; c < ch; c++)
            for (int i = 0; i < k; i++)
                for (int j = 0; j < k; j++)
                    a += img_v(c, r * s + i, x * s + j) * flt_v(c, i, j);
        return a;
    endfunction

    task automatic fill_uniform(input int d, input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] f);
        case (d)
            0: begin
                for (int e = 0; e < C0*H0*W0; e++) img0[e*32 +: 32] = v0;
                for (int e = 0; e < C0*K0*K0; e++) flt0[e*32 +: 32] = f;
            end
            1: begin
                for (int e = 0; e < C1*H1*W1; e++) img1[e*32 +: 32] = v0;
                for (int e = 0; e < C1*K1*K1; e++) flt1[e*32 +: 32] = f;
            end
            default: begin
                for (int e = 0; e < H2*W2; e++) begin
                    img2[e*32 +: 32]           = v0;
                    img2[(H2*W2 + e)*32 +: 32] = v1;
                end
                for (int e = 0; e < C2*K2*K2; e++) flt2[e*32 +: 32] = f;
            end
        endcase
    endtask

    task automatic fill_pattern(input int d);
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 8; r++)
                for (int x = 0; x < 8; x++) begin
                    if (d == 1 && c == 0) img1[((c*8 + r)*8 + x)*32 +: 32] = i2f(img_v(c, r, x));
                    if (d == 2)           img2[((c*8 + r)*8 + x)*32 +: 32] = i2f(img_v(c, r, x));
                end
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    if (d == 1 && c == 0) flt1[((c*3 + i)*3 + j)*32 +: 32] = i2f(flt_v(c, i, j));
                    if (d == 2)           flt2[((c*3 + i)*3 + j)*32 +: 32] = i2f(flt_v(c, i, j));
                end
    endtask

    task automatic wait_done(input int d, input int maxc, output int at);
        at = -1;
        for (int n = 0; n < maxc; n++) begin
            @(negedge clk);
            if (get_done(d)) begin
                at = cyc;
                return;
            end
        end
    endtask

    // Latency counts the acceptance edge and the edge that raises done, both inclusive.
    task automatic run_dut(input int d, input string name, output int lat);
        int t0, at;
        @(negedge clk);
        set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
        t0 = cyc;
        chk({name, "_busy"}, {31'd0, get_busy(d)}, 32'd1);
        wait_done(d, 3000, at);
        lat = (at < 0) ? -1 : at - t0 + 1;
    endtask

    task automatic check_map(input string name, input int d, input int np, input logic [31:0] req);
        int          nbad = 0;
        logic [31:0] first = 32'd0;
        for (int p = 0; p < np; p++)
            if (get_pix(d, p) !== req) begin
                if (nbad == 0) first = get_pix(d, p);
                nbad++;
            end
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL %s: %0d pixels wrong, first got %h want %h", name, nbad, first, req);
        end
    endtask

    initial begin
        int          lat, a0, a1, a2, t0;
        logic [31:0] neg9;
`ifdef CONV_RELU_EN
        neg9 = 32'h00000000;
`else
        neg9 = 32'hC1100000;
`endif
        vt[0] = '{"zero_flt",  0, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h00000000, 1457};
        vt[1] = '{"s2_ones",   1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h41100000, 31};
        vt[2] = '{"ch2_12",    2, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h41D80000, 58};
        vt[3] = '{"s2_negflt", 1, 32'h3F800000, 32'h3F800000, 32'hBF800000, neg9,         31};
        vt[4] = '{"ch2_half",  2, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h41580000, 58};
        vt[5] = '{"s2_mixexp", 1, 32'h3FC00000, 32'h3FC00000, 32'h40000000, 32'h41D80000, 31};
        vt[6] = '{"full_4x4",  0, 32'h40800000, 32'h40800000, 32'h40800000, 32'h43C80000, 1457};

        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        st0 = 1'b0;  st1 = 1'b0;  st2 = 1'b0;
        img0 = '0; img1 = '0; img2 = '0; flt0 = '0; flt1 = '0; flt2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_busy%0d", d), {31'd0, get_busy(d)}, 32'd0);
            chk($sformatf("rst_done%0d", d), {31'd0, get_done(d)}, 32'd0);
        end
        chk("rst_out0", {31'd0, |out0}, 32'd0);
        chk("rst_out1", {31'd0, |out1}, 32'd0);
        chk("rst_out2", {31'd0, |out2}, 32'd0);

        for (int v = 0; v < 7; v++) begin
            fill_uniform(vt[v].d, vt[v].i0, vt[v].i1, vt[v].f);
            run_dut(vt[v].d, vt[v].name, lat);
            chk({vt[v].name, "_lat"}, lat, vt[v].lat);
            check_map({vt[v].name, "_map"}, vt[v].d, (vt[v].d == 0) ? NP0 : (vt[v].d == 1) ? NP1 : NP2, vt[v].px);
        end

        fill_pattern(1);
        run_dut(1, "pat1", lat);
        chk("pat1_lat", lat, 31);
        for (int p = 0; p < NP1; p++)
            chk($sformatf("pat1_px%0d", p), get_pix(1, p), i2f(ref_px(K1, S1, C1, p / OW1, p % OW1)));
        fill_pattern(2);
        run_dut(2, "pat2", lat);
        chk("pat2_lat", lat, 58);
        for (int p = 0; p < NP2; p++)
            chk($sformatf("pat2_px%0d", p), get_pix(2, p), i2f(ref_px(K2, S2, C2, p / OW2, p % OW2)));

        // Abort a run with reset: map of 400.0 from the previous run must be wiped.
        @(negedge clk);
        st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        repeat (9) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_done", {31'd0, done0}, 32'd0);
        chk("abort_out",  out0[31:0] | out0[NP0*32-1 -: 32], 32'd0);
        chk("abort_outall", {31'd0, |out0}, 32'd0);
        rst0 = 1'b0;
        run_dut(0, "restart", lat);
        chk("restart_lat", lat, 1457);
        check_map("restart_map", 0, NP0, 32'h43C80000);

        // Mid-run start pulse, then start held: runs repeat every NB*TB+2 cycles.
        fill_uniform(1, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        @(negedge clk);
        st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        t0 = cyc;
        repeat (4) @(negedge clk);
        st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        @(negedge clk);
        st1 = 1'b1;
        wait_done(1, 100, a0);
        wait_done(1, 100, a1);
        wait_done(1, 100, a2);
        st1 = 1'b0;
        chk("b2b_first", (a0 < 0) ? -1 : a0 - t0, 30);
        chk("b2b_gap1",  (a0 < 0 || a1 < 0) ? -1 : a1 - a0, 32);
        chk("b2b_gap2",  (a1 < 0 || a2 < 0) ? -1 : a2 - a1, 32);
        repeat (3) @(negedge clk);
        chk("b2b_idle", {31'd0, busy1}, 32'd0);
        check_map("b2b_map", 1, NP1, 32'h41100000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
